// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// State encoding is exposed on the debug/CSR port.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILTER = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int RETRY_W = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage reset-to-0 synchroniser for asynchronous status bits.
// Output is the last flop of the chain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: hold, wait for lock with retries, filter,
// then release the system reset; re-sequences on lock loss.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clock_in,
  input  logic               resetn,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_resetb,
  output logic               sys_resetn,
  output logic               locked,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int CNT_W = clog2(max3(RESET_HOLD_CYCLES,
    LOCK_TIMEOUT_CYCLES, LOCK_FILTER_CYCLES));

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST =
    CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("RESET_HOLD_CYCLES must be >= 1");
  end
  if (LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("LOCK_TIMEOUT_CYCLES must be >= 1");
  end
  if (LOCK_FILTER_CYCLES < 1) begin : g_bad_filt
    $error("LOCK_FILTER_CYCLES must be >= 1");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retry
    $error("MAX_RETRIES must be in 0..15");
  end

  logic               w_lock_s;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               r_pll_resetb;
  logic               r_sys_resetn;
  logic               r_locked;
  logic               r_fault;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (clock_in),
    .i_rst_n (resetn),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    if (force_relock) begin
      w_state_nxt = ST_HOLD;
      if (r_state == ST_FAULT) w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == HOLD_LAST) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_lock_s) begin
            w_state_nxt = ST_FILTER;
          end else if (r_cnt == TO_LAST) begin
            if (MAX_RETRIES != 0 && r_retry == RETRY_MAX) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_state_nxt = ST_HOLD;
              // Unlimited mode saturates instead of wrapping.
              if (r_retry != '1) w_retry_nxt = r_retry + 1'b1;
            end
          end
        end
        ST_FILTER: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (!w_lock_s) begin
            w_state_nxt = ST_WAIT;
          end else if (r_cnt == FILT_LAST) begin
            w_state_nxt = ST_RUN;
            w_retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) w_state_nxt = ST_HOLD;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_HOLD;
        end
      endcase
    end
    if (force_relock || w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_resetn <= 1'b0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_resetb <= !(w_state_nxt == ST_HOLD ||
                        w_state_nxt == ST_FAULT);
      r_sys_resetn <= (w_state_nxt == ST_RUN);
      r_locked     <= (w_state_nxt == ST_RUN);
      r_fault      <= (w_state_nxt == ST_FAULT);
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign sys_resetn  = r_sys_resetn;
  assign locked      = r_locked;
  assign fault       = r_fault;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule
